cam_lru_param: RTL and testbench
================================

Name: cam_lru_param

Overview:
- Parametrised, fully associative content-addressable memory with true-LRU replacement.
- Next generation of the fixed 8x16x16 CAM: size and key/value widths are configurable; adds valid tracking, an invalidate operation, an occupancy count and a registered hit/miss response.
- Sits behind the cam_types definitions. mru_p / lru_p semantics still apply: recency position 0 is MRU, position CAMSIZE-1 is LRU.

Parameters:
- CAMSIZE, 8, number of entries; power of two, >= 2.
- KEY_W, 16, key width in bits.
- VAL_W, 16, value width in bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present this cycle; one request accepted per cycle, no backpressure.
- req_op  in  2  00 READ, 01 WRITE, 10 INVALIDATE, 11 reserved (treated as no-op, resp_err=1).
- req_key  in  KEY_W  lookup key.
- req_val  in  VAL_W  write data (WRITE only).
- resp_valid  out  1  response for the request of the previous cycle.
- resp_hit  out  1  key matched a valid entry.
- resp_val  out  VAL_W  READ hit: stored value; otherwise 0.
- resp_err  out  1  READ miss or reserved op (maps to READ_ERROR in the bench).
- occupancy  out  $clog2(CAMSIZE)+1  number of valid entries, registered.

Behaviour:
- Storage: per entry valid, key, value. Recency stack order[0..CAMSIZE-1] of entry indices.
- Reset (async assert, sync-free deassert):
  - all valid=0; order[i]=i; occupancy=0.
  - resp_valid, resp_hit, resp_val, resp_err all 0.
  - Key and value arrays need no reset.
- Match: a combinational compare of req_key against all valid entries, made against state as it was before the edge. At most one entry may match; WRITE never creates duplicates.
- Latency: response registered exactly 1 cycle after a req_valid cycle. resp_valid=0 in cycles following req_valid=0; the other response outputs are then 0.
- READ hit: resp_hit=1, resp_val=value; the entry moves to order[0], and entries above it shift down by one.
- READ miss: resp_hit=0, resp_err=1, resp_val=0. No state change.
- WRITE hit: the value is overwritten and the entry moves to MRU. resp_hit=1.
- WRITE miss: resp_hit=0.
  - If any invalid entry exists, allocate the lowest-index invalid entry; occupancy+1.
  - Otherwise evict the entry at order[CAMSIZE-1]; occupancy is unchanged.
  - In both cases: write key and value, set valid=1, move the entry to MRU.
- INVALIDATE hit: valid=0, the entry moves to order[CAMSIZE-1] and the others shift up; occupancy-1. resp_hit=1.
- INVALIDATE miss: no state change. resp_hit=0, resp_err=0.
- Back-to-back requests: a request at cycle N+1 sees all updates from cycle N (for example, READ after WRITE of the same key hits with the new data).
- Occupancy saturates at CAMSIZE by construction and never underflows.
- Reset mid-operation: a pending response is dropped; the next cycle after deassert shows resp_valid=0.

Optional Feature:
- Macro: CAM_EVICT_REPORT_EN.
- When defined, three extra output ports are added:
  - evict_valid  1
  - evict_key  KEY_W
  - evict_val  VAL_W
- These are registered alongside the response. evict_valid=1 only for a WRITE miss that replaced a valid entry, and carries that entry's old key and value. All three reset to 0.
- When undefined, the ports are absent and there is no eviction logic.

Test Plan:
- Reset, then READ key 0x1234: next cycle resp_valid=1, resp_hit=0, resp_err=1; occupancy=0.
- WRITE key 0x0001 val 0xAAAA, then READ 0x0001 the next cycle: resp_hit=1, resp_val=0xAAAA; occupancy=1.
- Fill with keys 0..7, READ key 0, then WRITE key 8:
  - key 1 (the LRU) is evicted and READ 1 misses; READ 0 still hits.
  - With CAM_EVICT_REPORT_EN: evict_key=1.
- WRITE key 5 val 0x1111, then WRITE key 5 val 0x2222: occupancy unchanged; READ 5 returns 0x2222.
- Full CAM, INVALIDATE key 3, then WRITE new key 9:
  - occupancy drops 8 -> 7 -> 8.
  - Key 9 reuses key 3's slot and no valid entry is evicted (evict_valid=0).
- Assert rst_n low for 1 cycle mid-stream (during a WRITE): all subsequent READs miss, occupancy=0, resp_valid=0 on the first cycle after release.

Source files
------------

// File: rtl/cam_lru_param.sv
// cam_lru_param: parametrised fully associative CAM with true-LRU replacement.
// Each entry holds valid/key/value; a recency stack order_q[0..CAMSIZE-1]
// tracks use (position 0 = MRU, position CAMSIZE-1 = LRU).
// Responses and occupancy are registered one cycle after the request.
// Optional feature macro: CAM_EVICT_REPORT_EN adds evict_valid/evict_key/evict_val
// outputs describing the valid entry displaced by a WRITE miss.
module cam_lru_param #(
  parameter int CAMSIZE = 8,
  parameter int KEY_W   = 16,
  parameter int VAL_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  input  logic [1:0]                 req_op,
  input  logic [KEY_W-1:0]           req_key,
  input  logic [VAL_W-1:0]           req_val,
  output logic                       resp_valid,
  output logic                       resp_hit,
  output logic [VAL_W-1:0]           resp_val,
  output logic                       resp_err,
`ifdef CAM_EVICT_REPORT_EN
  output logic                       evict_valid,
  output logic [KEY_W-1:0]           evict_key,
  output logic [VAL_W-1:0]           evict_val,
`endif
  output logic [$clog2(CAMSIZE):0]   occupancy
);

  localparam int IDX_W = $clog2(CAMSIZE);
  localparam int OCC_W = $clog2(CAMSIZE) + 1;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INV   = 2'b10;

  // State
  logic [CAMSIZE-1:0] valid_q, valid_d;
  logic [IDX_W-1:0]   order_q [CAMSIZE];
  logic [IDX_W-1:0]   order_d [CAMSIZE];
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [KEY_W-1:0]   key_q [CAMSIZE];
  logic [VAL_W-1:0]   val_q [CAMSIZE];

  logic               resp_valid_q, resp_valid_d;
  logic               resp_hit_q, resp_hit_d;
  logic [VAL_W-1:0]   resp_val_q, resp_val_d;
  logic               resp_err_q, resp_err_d;
`ifdef CAM_EVICT_REPORT_EN
  logic               evict_valid_q, evict_valid_d;
  logic [KEY_W-1:0]   evict_key_q, evict_key_d;
  logic [VAL_W-1:0]   evict_val_q, evict_val_d;
`endif

  // Lookup / allocation helpers
  logic               hit_s;
  logic [IDX_W-1:0]   hit_idx_s;
  logic               any_free_s;
  logic [IDX_W-1:0]   free_idx_s;
  logic [IDX_W-1:0]   tgt_idx_s;
  logic [IDX_W-1:0]   tgt_pos_s;
  logic [IDX_W-1:0]   mru_order_s [CAMSIZE];
  logic [IDX_W-1:0]   lru_order_s [CAMSIZE];
  logic               wr_en_s;

  // Match, free-slot search, target selection and reordered recency stacks
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = '0;
    free_idx_s = '0;
    any_free_s = ~(&valid_q);
    // descending scan so the lowest matching / lowest free index wins
    for (int i = CAMSIZE - 1; i >= 0; i--) begin
      hit_s      = hit_s | (valid_q[i] && (key_q[i] == req_key));
      hit_idx_s  = (valid_q[i] && (key_q[i] == req_key)) ? IDX_W'(i) : hit_idx_s;
      free_idx_s = (!valid_q[i]) ? IDX_W'(i) : free_idx_s;
    end
    // hit entry, else lowest free slot, else the LRU victim
    tgt_idx_s = hit_s ? hit_idx_s : (any_free_s ? free_idx_s : order_q[CAMSIZE-1]);
    tgt_pos_s = '0;
    for (int i = CAMSIZE - 1; i >= 0; i--) begin
      tgt_pos_s = (order_q[i] == tgt_idx_s) ? IDX_W'(i) : tgt_pos_s;
    end
    // move target to MRU: entries above it shift down one position
    mru_order_s[0] = tgt_idx_s;
    for (int i = 1; i < CAMSIZE; i++) begin
      mru_order_s[i] = (IDX_W'(i) <= tgt_pos_s) ? order_q[i-1] : order_q[i];
    end
    // move target to LRU: entries below it shift up one position
    lru_order_s[CAMSIZE-1] = tgt_idx_s;
    for (int i = 0; i < CAMSIZE - 1; i++) begin
      lru_order_s[i] = (IDX_W'(i) >= tgt_pos_s) ? order_q[i+1] : order_q[i];
    end
  end

  // Next-state and response decode per operation
  always_comb begin
    valid_d      = valid_q;
    order_d      = order_q;
    occ_d        = occ_q;
    wr_en_s      = 1'b0;
    resp_valid_d = req_valid;
    resp_hit_d   = 1'b0;
    resp_val_d   = '0;
    resp_err_d   = 1'b0;
`ifdef CAM_EVICT_REPORT_EN
    evict_valid_d = 1'b0;
    evict_key_d   = '0;
    evict_val_d   = '0;
`endif
    if (req_valid) begin
      case (req_op)
        OP_READ: begin
          if (hit_s) begin
            order_d    = mru_order_s;
            resp_hit_d = 1'b1;
            resp_val_d = val_q[hit_idx_s];
          end else begin
            resp_err_d = 1'b1;
          end
        end
        OP_WRITE: begin
          wr_en_s             = 1'b1;
          valid_d[tgt_idx_s]  = 1'b1;
          order_d             = mru_order_s;
          resp_hit_d          = hit_s;
          if (!hit_s && any_free_s) begin
            occ_d = occ_q + OCC_W'(1);
          end else begin
            occ_d = occ_q;
          end
`ifdef CAM_EVICT_REPORT_EN
          if (!hit_s && !any_free_s) begin
            evict_valid_d = 1'b1;
            evict_key_d   = key_q[tgt_idx_s];
            evict_val_d   = val_q[tgt_idx_s];
          end else begin
            evict_valid_d = 1'b0;
          end
`endif
        end
        OP_INV: begin
          if (hit_s) begin
            valid_d[tgt_idx_s] = 1'b0;
            order_d            = lru_order_s;
            occ_d              = occ_q - OCC_W'(1);
            resp_hit_d         = 1'b1;
          end else begin
            resp_hit_d = 1'b0;
          end
        end
        default: begin
          resp_err_d = 1'b1;
        end
      endcase
    end else begin
      resp_valid_d = 1'b0;
    end
  end

  // Control state and registered response with async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      occ_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_val_q   <= '0;
      resp_err_q   <= 1'b0;
      for (int i = 0; i < CAMSIZE; i++) begin
        order_q[i] <= IDX_W'(i);
      end
`ifdef CAM_EVICT_REPORT_EN
      evict_valid_q <= 1'b0;
      evict_key_q   <= '0;
      evict_val_q   <= '0;
`endif
    end else begin
      valid_q      <= valid_d;
      occ_q        <= occ_d;
      order_q      <= order_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_val_q   <= resp_val_d;
      resp_err_q   <= resp_err_d;
`ifdef CAM_EVICT_REPORT_EN
      evict_valid_q <= evict_valid_d;
      evict_key_q   <= evict_key_d;
      evict_val_q   <= evict_val_d;
`endif
    end
  end

  // Key/value storage; contents are qualified by valid_q so no reset needed
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      key_q[tgt_idx_s] <= req_key;
      val_q[tgt_idx_s] <= req_val;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_val   = resp_val_q;
  assign resp_err   = resp_err_q;
  assign occupancy  = occ_q;
`ifdef CAM_EVICT_REPORT_EN
  assign evict_valid = evict_valid_q;
  assign evict_key   = evict_key_q;
  assign evict_val   = evict_val_q;
`endif

endmodule

// File: tb/tb_cam_lru_param.sv
// Directed self-checking bench for cam_lru_param (CAMSIZE=8, 16-bit key/value).
module tb_cam_lru_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [15:0] req_key;
  logic [15:0] req_val;
  logic        resp_valid;
  logic        resp_hit;
  logic [15:0] resp_val;
  logic        resp_err;
  logic [3:0]  occupancy;
`ifdef CAM_EVICT_REPORT_EN
  logic        evict_valid;
  logic [15:0] evict_key;
  logic [15:0] evict_val;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [1:0] RD  = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] INV = 2'b10;
  localparam logic [1:0] RSV = 2'b11;

  cam_lru_param #(.CAMSIZE(8), .KEY_W(16), .VAL_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_key    (req_key),
    .req_val    (req_val),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_val   (resp_val),
    .resp_err   (resp_err),
`ifdef CAM_EVICT_REPORT_EN
    .evict_valid(evict_valid),
    .evict_key  (evict_key),
    .evict_val  (evict_val),
`endif
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // drive one request for one cycle; outputs sampled 1ns after the edge
  task automatic issue(input logic [1:0] op, input logic [15:0] key, input logic [15:0] val);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    req_val   = val;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_key   = 16'h0000;
    req_val   = 16'h0000;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // check a READ response: hit flag, value, err, occupancy
  task automatic chk_rd(input string tag, input logic hit, input logic [15:0] val, input logic [3:0] occ);
    chk({tag, "_vld"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_hit"}, {31'd0, resp_hit}, {31'd0, hit});
    chk({tag, "_val"}, {16'd0, resp_val}, {16'd0, val});
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, ~hit});
    chk({tag, "_occ"}, {28'd0, occupancy}, {28'd0, occ});
  endtask

  initial begin
    req_valid = 1'b0; req_op = 2'b00; req_key = 16'h0000; req_val = 16'h0000;
    do_reset();
    chk("rst_vld", {31'd0, resp_valid}, 32'd0);
    chk("rst_hit", {31'd0, resp_hit}, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_occ", {28'd0, occupancy}, 32'd0);

    // empty CAM read miss
    issue(RD, 16'h1234, 16'h0000);
    chk_rd("rd_empty", 1'b0, 16'h0000, 4'd0);

    // write then back-to-back read of same key
    issue(WR, 16'h0001, 16'hAAAA);
    chk("wr1_hit", {31'd0, resp_hit}, 32'd0);
    chk("wr1_occ", {28'd0, occupancy}, 32'd1);
    issue(RD, 16'h0001, 16'h0000);
    chk_rd("rd1", 1'b1, 16'hAAAA, 4'd1);
    idle();
    chk("idle_vld", {31'd0, resp_valid}, 32'd0);
    chk("idle_hit", {31'd0, resp_hit}, 32'd0);
    chk("idle_val", {16'd0, resp_val}, 32'd0);

    // fill keys 0..7, then LRU eviction after touching key 0
    do_reset();
    for (int k = 0; k < 8; k++) issue(WR, 16'(k), 16'(16'h0100 + k));
    chk("fill_occ", {28'd0, occupancy}, 32'd8);
    issue(RD, 16'h0000, 16'h0000);
    chk_rd("rd0", 1'b1, 16'h0100, 4'd8);
    issue(WR, 16'h0008, 16'h0108);
    chk("wr8_hit", {31'd0, resp_hit}, 32'd0);
    chk("wr8_occ", {28'd0, occupancy}, 32'd8);
`ifdef CAM_EVICT_REPORT_EN
    chk("wr8_ev_vld", {31'd0, evict_valid}, 32'd1);
    chk("wr8_ev_key", {16'd0, evict_key}, 32'h0001);
    chk("wr8_ev_val", {16'd0, evict_val}, 32'h0101);
`endif
    issue(RD, 16'h0001, 16'h0000);
    chk_rd("rd1_evicted", 1'b0, 16'h0000, 4'd8);
    issue(RD, 16'h0000, 16'h0000);
    chk_rd("rd0_kept", 1'b1, 16'h0100, 4'd8);
    issue(RD, 16'h0008, 16'h0000);
    chk_rd("rd8", 1'b1, 16'h0108, 4'd8);

    // overwrite existing key
    issue(WR, 16'h0005, 16'h1111);
    chk("wr5a_hit", {31'd0, resp_hit}, 32'd1);
    issue(WR, 16'h0005, 16'h2222);
    chk("wr5b_hit", {31'd0, resp_hit}, 32'd1);
    chk("wr5b_occ", {28'd0, occupancy}, 32'd8);
    issue(RD, 16'h0005, 16'h0000);
    chk_rd("rd5", 1'b1, 16'h2222, 4'd8);

    // invalidate then refill reusing the freed slot
    issue(INV, 16'h0003, 16'h0000);
    chk("inv3_hit", {31'd0, resp_hit}, 32'd1);
    chk("inv3_occ", {28'd0, occupancy}, 32'd7);
    issue(INV, 16'h0003, 16'h0000);
    chk("inv3b_hit", {31'd0, resp_hit}, 32'd0);
    chk("inv3b_err", {31'd0, resp_err}, 32'd0);
    chk("inv3b_occ", {28'd0, occupancy}, 32'd7);
    issue(WR, 16'h0009, 16'h0109);
    chk("wr9_occ", {28'd0, occupancy}, 32'd8);
`ifdef CAM_EVICT_REPORT_EN
    chk("wr9_ev_vld", {31'd0, evict_valid}, 32'd0);
`endif
    issue(RD, 16'h0009, 16'h0000);
    chk_rd("rd9", 1'b1, 16'h0109, 4'd8);
    issue(RD, 16'h0003, 16'h0000);
    chk_rd("rd3", 1'b0, 16'h0000, 4'd8);

    // reserved op
    issue(RSV, 16'h0009, 16'h0000);
    chk("rsv_vld", {31'd0, resp_valid}, 32'd1);
    chk("rsv_hit", {31'd0, resp_hit}, 32'd0);
    chk("rsv_err", {31'd0, resp_err}, 32'd1);

    // recency now (MRU..LRU keys): 9,5,8,0,7,6,4,2 -> key 2 is the victim
    issue(WR, 16'h000A, 16'h010A);
    chk("wrA_hit", {31'd0, resp_hit}, 32'd0);
`ifdef CAM_EVICT_REPORT_EN
    chk("wrA_ev_key", {16'd0, evict_key}, 32'h0002);
`endif
    issue(RD, 16'h0002, 16'h0000);
    chk_rd("rd2_evicted", 1'b0, 16'h0000, 4'd8);
    issue(RD, 16'h0004, 16'h0000);
    chk_rd("rd4_kept", 1'b1, 16'h0104, 4'd8);

    // reset pulse during a WRITE
    req_valid = 1'b1; req_op = WR; req_key = 16'h000B; req_val = 16'h010B;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 1'b0;
    chk("rstmid_vld", {31'd0, resp_valid}, 32'd0);
    chk("rstmid_occ", {28'd0, occupancy}, 32'd0);
    @(posedge clk);
    #1;
    chk("rstmid_vld2", {31'd0, resp_valid}, 32'd0);
    issue(RD, 16'h000B, 16'h0000);
    chk_rd("rstmid_rdB", 1'b0, 16'h0000, 4'd0);
    issue(RD, 16'h0000, 16'h0000);
    chk_rd("rstmid_rd0", 1'b0, 16'h0000, 4'd0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
